// File: rtl/spi_regfile_periph_if.sv
// SPI pin bundle between the bus controller (master) and the register-file peripheral (slave).
interface spi_regfile_periph_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output ncs, sclk, copi, input cipo, cipo_oe);
  modport slave  (input ncs, sclk, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register file: R/W bit, address, data, MSB first; writes commit after ncs rises,
// reads shift the addressed register out on cipo; malformed frames are counted.
module spi_regfile_periph #(
  parameter int                NUM_REGS  = 5,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_periph_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err,
  output logic [7:0]                 err_count
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]   CNT_CMD  = CW'(ADDR_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FRAME_LEN);
  localparam logic [ADDR_W:0] NR       = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t                             state;
  logic [2:0]                         ncs_q, sclk_q;
  logic [1:0]                         copi_q;
  logic [1:0]                         settle;
  logic                               armed;
  logic [CW-1:0]                      cnt;
  logic [FRAME_LEN-1:0]               rx;
  logic [DATA_W-1:0]                  tx;
  logic                               overrun, rd_frame, commit;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs;

  logic ncs_rise, ncs_fall, sclk_rise, sclk_fall, copi_s;
  assign ncs_rise  =  ncs_q[1] & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign copi_s    =  copi_q[1];

  assign regs_flat = regs;

  // Address as it stands when the last address bit is being sampled.
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] rd_val;
  assign cmd_addr = {rx[ADDR_W-2:0], copi_s};

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (cmd_addr == ADDR_W'(k)) rd_val = regs[k];
  end

  logic              fr_rw, addr_ok;
  logic [ADDR_W-1:0] fr_addr;
  logic [DATA_W-1:0] fr_data;
  assign fr_rw   = rx[FRAME_LEN-1];
  assign fr_addr = rx[DATA_W +: ADDR_W];
  assign fr_data = rx[DATA_W-1:0];
  assign addr_ok = {1'b0, fr_addr} < NR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_q  <= 3'b111;
      sclk_q <= '0;
      copi_q <= '0;
    end else begin
      ncs_q  <= {ncs_q[1:0], spi.ncs};
      sclk_q <= {sclk_q[1:0], spi.sclk};
      copi_q <= {copi_q[0], spi.copi};
    end
  end

  // A frame can only start once ncs has been seen high on real pin samples, so a frame
  // already in flight when reset releases is never decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end else if (ncs_q[1]) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      overrun   <= 1'b0;
      rd_frame  <= 1'b0;
      commit    <= 1'b0;
      spi.cipo    <= 1'b0;
      spi.cipo_oe <= 1'b0;
      regs      <= {NUM_REGS{RESET_VAL}};
      wr_strobe <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      commit    <= 1'b0;

      if (commit) begin
        if (overrun || (cnt != '0 && cnt != CNT_FULL) || (cnt == CNT_FULL && fr_rw && !addr_ok)) begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (cnt == CNT_FULL && fr_rw) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (fr_addr == ADDR_W'(k)) begin
              regs[k]      <= fr_data;
              wr_strobe[k] <= 1'b1;
            end
        end
      end

      // ncs rising wins over any sclk edge detected in the same cycle.
      if (state != IDLE && ncs_rise) begin
        state       <= IDLE;
        commit      <= 1'b1;
        spi.cipo    <= 1'b0;
        spi.cipo_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ncs_fall && armed) begin
            state   <= CMD;
            cnt     <= '0;
            rx      <= '0;
            overrun <= 1'b0;
          end
          CMD: if (sclk_rise) begin
            rx  <= {rx[FRAME_LEN-2:0], copi_s};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_CMD) begin
              state       <= DATA;
              rd_frame    <= ~rx[ADDR_W-1];
              spi.cipo_oe <= ~rx[ADDR_W-1];
              tx          <= rd_val;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx  <= {rx[FRAME_LEN-2:0], copi_s};
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) state <= HOLD;
            end else if (sclk_fall && rd_frame) begin
              spi.cipo <= tx[DATA_W-1];
              tx       <= {tx[DATA_W-2:0], 1'b0};
            end
          end
          HOLD: if (sclk_rise) overrun <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
